bram_ext_arbiter: RTL and testbench

Round-robin arbiter that shares the single external memory interface between the NUM_BRAMS buffer units. Each requester submits one load or store burst command, made of a direction, a base address and a beat count. The block sequences each burst through command issue, beat counting and completion, and then hands the interface to the next requester in rotation. It sits between the BRAM units and the external-memory load/store path.

---
 rtl/bram_ext_arbiter.sv | 147 ++++++++++++++
 tb/tb_bram_ext_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_ext_arbiter.sv
// Round-robin arbiter sharing one external load/store command port between NUM_REQ BRAM units.
// Each grant runs one burst: command issue, beat counting, then a one-cycle completion pulse.
//
// state | meaning
// IDLE  | scan requests from rr_ptr; latch the winner's command
// CMD   | command presented on the external port until acknowledged
// XFER  | counting data beats until the latched length is reached
// DONE  | completion pulse to the winner; rotate priority pointer
module bram_ext_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH_ADDR = 32,
    parameter int WIDTH_LEN  = 10
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            I_Req,
    input  logic [NUM_REQ-1:0]            I_Store,
    input  logic [NUM_REQ*WIDTH_ADDR-1:0] I_Addr,
    input  logic [NUM_REQ*WIDTH_LEN-1:0]  I_Len,
    output logic [NUM_REQ-1:0]            O_Grant,
    output logic [NUM_REQ-1:0]            O_Done,
    output logic                          O_Ext_Req,
    output logic                          O_Ext_St,
    output logic [WIDTH_ADDR-1:0]         O_Ext_Addr,
    output logic [WIDTH_LEN-1:0]          O_Ext_Len,
    input  logic                          I_Ext_Ack,
    input  logic                          I_Ext_Beat,
    output logic                          O_Busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]        win_q, win_d;
    logic                    st_q, st_d;
    logic [WIDTH_ADDR-1:0]   addr_q, addr_d;
    logic [WIDTH_LEN-1:0]    len_q, len_d;
    logic [WIDTH_LEN-1:0]    beat_cnt_q, beat_cnt_d;

    logic                    found;
    logic [PTR_W-1:0]        scan_idx;
    logic [PTR_W-1:0]        cand;
    logic [WIDTH_LEN-1:0]    scan_len;

    // Priority scan starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found    = 1'b0;
        scan_idx = '0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && I_Req[cand]) begin
                found    = 1'b1;
                scan_idx = cand;
            end
        end
        scan_len = I_Len[int'(scan_idx)*WIDTH_LEN +: WIDTH_LEN];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            win_q      <= '0;
            st_q       <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            win_q      <= win_d;
            st_q       <= st_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        win_d      = win_q;
        st_d       = st_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = scan_idx;
                    st_d    = I_Store[scan_idx];
                    addr_d  = I_Addr[int'(scan_idx)*WIDTH_ADDR +: WIDTH_ADDR];
                    len_d   = scan_len;
                    state_d = (scan_len == '0) ? DONE : CMD;
                end
            end
            CMD: begin
                if (I_Ext_Ack) begin
                    beat_cnt_d = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (I_Ext_Beat) begin
                    // Hold the count on the final beat so it can never wrap at maximum length.
                    if (beat_cnt_q == len_q - WIDTH_LEN'(1)) begin
                        state_d = DONE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + WIDTH_LEN'(1);
                    end
                end
            end
            DONE: begin
                rr_ptr_d = PTR_W'((int'(win_q) + 1) % NUM_REQ);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only.
    always_comb begin
        O_Grant    = '0;
        O_Done     = '0;
        O_Ext_Req  = (state_q == CMD);
        O_Ext_St   = st_q;
        O_Ext_Addr = addr_q;
        O_Ext_Len  = len_q;
        O_Busy     = (state_q != IDLE);
        if (state_q == CMD || state_q == XFER) begin
            O_Grant[win_q] = 1'b1;
        end
        if (state_q == DONE) begin
            O_Done[win_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_bram_ext_arbiter.sv
// Scoreboard bench for bram_ext_arbiter: expected commands and completions are queued
// as stimulus is driven and checked by a monitor as the DUT produces them.
module tb_bram_ext_arbiter;

    localparam int NR = 4;
    localparam int WA = 32;
    localparam int WL = 10;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     I_Req = '0;
    logic [NR-1:0]     I_Store = '0;
    logic [NR*WA-1:0]  I_Addr = '0;
    logic [NR*WL-1:0]  I_Len = '0;
    logic [NR-1:0]     O_Grant;
    logic [NR-1:0]     O_Done;
    logic              O_Ext_Req;
    logic              O_Ext_St;
    logic [WA-1:0]     O_Ext_Addr;
    logic [WL-1:0]     O_Ext_Len;
    logic              I_Ext_Ack = 1'b0;
    logic              I_Ext_Beat = 1'b0;
    logic              O_Busy;

    bram_ext_arbiter #(.NUM_REQ(NR), .WIDTH_ADDR(WA), .WIDTH_LEN(WL)) dut (
        .clock(clock), .reset(reset),
        .I_Req(I_Req), .I_Store(I_Store), .I_Addr(I_Addr), .I_Len(I_Len),
        .O_Grant(O_Grant), .O_Done(O_Done),
        .O_Ext_Req(O_Ext_Req), .O_Ext_St(O_Ext_St), .O_Ext_Addr(O_Ext_Addr), .O_Ext_Len(O_Ext_Len),
        .I_Ext_Ack(I_Ext_Ack), .I_Ext_Beat(I_Ext_Beat), .O_Busy(O_Busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          idx;
        logic        st;
        logic [WA-1:0] addr;
        logic [WL-1:0] len;
    } cmd_t;

    cmd_t cmd_q[$];
    int   done_q[$];
    int   tests_run = 0;
    int   fails = 0;
    logic prev_ext_req = 1'b0;
    cmd_t mc;
    int   md;

    // Monitor: new command edges and completion pulses are popped from the scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            prev_ext_req <= 1'b0;
        end else begin
            if (O_Ext_Req && !prev_ext_req) begin
                tests_run++;
                if (cmd_q.size() == 0) begin
                    fails++;
                    $display("FAIL mon_cmd unexpected command addr=%h len=%0d", O_Ext_Addr, O_Ext_Len);
                end else begin
                    mc = cmd_q.pop_front();
                    if (O_Ext_St !== mc.st || O_Ext_Addr !== mc.addr || O_Ext_Len !== mc.len ||
                        O_Grant !== (NR'(1) << mc.idx)) begin
                        fails++;
                        $display("FAIL mon_cmd got st=%b addr=%h len=%0d grant=%b, want st=%b addr=%h len=%0d req=%0d",
                                 O_Ext_St, O_Ext_Addr, O_Ext_Len, O_Grant, mc.st, mc.addr, mc.len, mc.idx);
                    end
                end
            end
            if (|O_Done) begin
                tests_run++;
                if (done_q.size() == 0) begin
                    fails++;
                    $display("FAIL mon_done unexpected done=%b", O_Done);
                end else begin
                    md = done_q.pop_front();
                    if (O_Done !== (NR'(1) << md)) begin
                        fails++;
                        $display("FAIL mon_done got %b want %b", O_Done, NR'(1) << md);
                    end
                end
            end
            if ($countones(O_Grant) > 1) begin
                fails++;
                $display("FAIL mon_onehot grant=%b", O_Grant);
            end
            prev_ext_req <= O_Ext_Req;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic st, input logic [WA-1:0] a, input logic [WL-1:0] l);
        I_Store[i] = st;
        I_Addr[i*WA +: WA] = a;
        I_Len[i*WL +: WL] = l;
    endtask

    task automatic push(input int i, input logic st, input logic [WA-1:0] a, input logic [WL-1:0] l);
        cmd_t c;
        c.idx = i; c.st = st; c.addr = a; c.len = l;
        cmd_q.push_back(c);
        done_q.push_back(i);
    endtask

    task automatic hard_reset();
        reset = 1'b0;
        I_Req = '0; I_Ext_Ack = 1'b0; I_Ext_Beat = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    // Waits (bounded) for a command, acks after ack_dly cycles, then pulses nbeats beats.
    task automatic serve(input int ack_dly, input int nbeats);
        int n = 0;
        while (!O_Ext_Req && n < 20) begin
            tick();
            n++;
        end
        tests_run++;
        if (!O_Ext_Req) begin
            fails++;
            $display("FAIL serve_timeout ext_req=%b want 1", O_Ext_Req);
            return;
        end
        repeat (ack_dly) tick();
        I_Ext_Ack = 1'b1; tick(); I_Ext_Ack = 1'b0;
        I_Ext_Beat = 1'b1; repeat (nbeats) tick(); I_Ext_Beat = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        tests_run++;
        if (O_Grant !== 4'b0 || O_Done !== 4'b0 || O_Ext_Req !== 1'b0 || O_Ext_St !== 1'b0 ||
            O_Ext_Addr !== 32'h0 || O_Ext_Len !== 10'h0 || O_Busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_vals grant=%b done=%b req=%b st=%b addr=%h len=%0d busy=%b want all 0",
                     O_Grant, O_Done, O_Ext_Req, O_Ext_St, O_Ext_Addr, O_Ext_Len, O_Busy);
        end
        hard_reset();
    endtask

    task automatic test_single_load();
        set_req(2, 1'b0, 32'h1000, 10'd3);
        push(2, 1'b0, 32'h1000, 10'd3);
        I_Req = 4'b0100;
        tick();
        tests_run++;
        if (O_Grant !== 4'b0100 || O_Ext_Req !== 1'b1 || O_Busy !== 1'b1) begin
            fails++;
            $display("FAIL single_cmd grant=%b req=%b busy=%b want 0100 1 1", O_Grant, O_Ext_Req, O_Busy);
        end
        I_Ext_Ack = 1'b1; tick(); I_Ext_Ack = 1'b0;
        tests_run++;
        if (O_Grant !== 4'b0100 || O_Ext_Req !== 1'b0) begin
            fails++;
            $display("FAIL single_xfer grant=%b req=%b want 0100 0", O_Grant, O_Ext_Req);
        end
        I_Ext_Beat = 1'b1; repeat (2) tick();
        tests_run++;
        if (O_Done !== 4'b0000 || O_Grant !== 4'b0100) begin
            fails++;
            $display("FAIL single_early done=%b grant=%b want 0000 0100", O_Done, O_Grant);
        end
        tick(); I_Ext_Beat = 1'b0;
        tests_run++;
        if (O_Done !== 4'b0100 || O_Grant !== 4'b0000) begin
            fails++;
            $display("FAIL single_done done=%b grant=%b want 0100 0000", O_Done, O_Grant);
        end
        I_Req = 4'b0000;
        tick();
        tests_run++;
        if (O_Busy !== 1'b0 || O_Done !== 4'b0000) begin
            fails++;
            $display("FAIL single_idle busy=%b done=%b want 0 0000", O_Busy, O_Done);
        end
        // rr_ptr should now be 3: requester 3 beats requester 0.
        set_req(0, 1'b0, 32'h0, 10'd0);
        set_req(3, 1'b0, 32'h0, 10'd0);
        done_q.push_back(3);
        done_q.push_back(0);
        I_Req = 4'b1001;
        tick();
        tests_run++;
        if (O_Done !== 4'b1000) begin
            fails++;
            $display("FAIL single_ptr3 done=%b want 1000", O_Done);
        end
        I_Req = 4'b0001;
        repeat (2) tick();
        tests_run++;
        if (O_Done !== 4'b0001) begin
            fails++;
            $display("FAIL single_ptr0 done=%b want 0001", O_Done);
        end
        I_Req = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        hard_reset();
        for (int i = 0; i < NR; i++) set_req(i, i[0], 32'h100 * i, 10'd1);
        for (int k = 0; k < 5; k++) push(k % NR, k[0], 32'h100 * (k % NR), 10'd1);
        I_Req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            serve(0, 1);
            if (k == 4) I_Req = 4'b0000;
            tests_run++;
            if (O_Done !== (NR'(1) << (k % NR))) begin
                fails++;
                $display("FAIL rr_order step=%0d done=%b want %b", k, O_Done, NR'(1) << (k % NR));
            end
        end
        tick();
    endtask

    task automatic test_ack_stall();
        set_req(1, 1'b1, 32'h2000_0040, 10'd4);
        push(1, 1'b1, 32'h2000_0040, 10'd4);
        I_Req = 4'b0010;
        tick();
        I_Ext_Beat = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (O_Ext_Req !== 1'b1 || O_Ext_Addr !== 32'h2000_0040 || O_Ext_Len !== 10'd4 || O_Ext_St !== 1'b1) begin
                fails++;
                $display("FAIL stall_hold cyc=%0d req=%b addr=%h len=%0d st=%b want 1 20000040 4 1",
                         c, O_Ext_Req, O_Ext_Addr, O_Ext_Len, O_Ext_St);
            end
            tick();
        end
        I_Ext_Beat = 1'b0;
        I_Ext_Ack = 1'b1; tick(); I_Ext_Ack = 1'b0;
        I_Ext_Beat = 1'b1; repeat (3) tick();
        tests_run++;
        if (O_Done !== 4'b0000 || O_Grant !== 4'b0010) begin
            fails++;
            $display("FAIL stall_count done=%b grant=%b want 0000 0010", O_Done, O_Grant);
        end
        tick(); I_Ext_Beat = 1'b0;
        I_Req = 4'b0000;
        tests_run++;
        if (O_Done !== 4'b0010) begin
            fails++;
            $display("FAIL stall_done done=%b want 0010", O_Done);
        end
        tick();
    endtask

    task automatic test_zero_len();
        set_req(1, 1'b0, 32'h0, 10'd0);
        set_req(2, 1'b0, 32'h0, 10'd0);
        done_q.push_back(1);
        I_Req = 4'b0010;
        tick();
        tests_run++;
        if (O_Done !== 4'b0010 || O_Grant !== 4'b0000 || O_Ext_Req !== 1'b0) begin
            fails++;
            $display("FAIL zero_done done=%b grant=%b req=%b want 0010 0000 0", O_Done, O_Grant, O_Ext_Req);
        end
        // rr_ptr should now be 2: requester 2 beats requester 1.
        done_q.push_back(2);
        done_q.push_back(1);
        I_Req = 4'b0110;
        repeat (2) tick();
        tests_run++;
        if (O_Done !== 4'b0100) begin
            fails++;
            $display("FAIL zero_ptr2 done=%b want 0100", O_Done);
        end
        I_Req = 4'b0010;
        repeat (2) tick();
        I_Req = 4'b0000;
        tests_run++;
        if (O_Done !== 4'b0010 || O_Ext_Req !== 1'b0) begin
            fails++;
            $display("FAIL zero_second done=%b req=%b want 0010 0", O_Done, O_Ext_Req);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        cmd_t c;
        set_req(2, 1'b0, 32'h4000, 10'd5);
        c.idx = 2; c.st = 1'b0; c.addr = 32'h4000; c.len = 10'd5;
        cmd_q.push_back(c);
        I_Req = 4'b0100;
        tick();
        I_Ext_Ack = 1'b1; tick(); I_Ext_Ack = 1'b0;
        I_Ext_Beat = 1'b1; repeat (2) tick();
        reset = 1'b0;
        #1;
        tests_run++;
        if (O_Grant !== 4'b0 || O_Done !== 4'b0 || O_Ext_Req !== 1'b0 || O_Busy !== 1'b0 ||
            O_Ext_Addr !== 32'h0 || O_Ext_Len !== 10'h0) begin
            fails++;
            $display("FAIL mid_reset grant=%b done=%b req=%b busy=%b addr=%h len=%0d want all 0",
                     O_Grant, O_Done, O_Ext_Req, O_Busy, O_Ext_Addr, O_Ext_Len);
        end
        I_Ext_Beat = 1'b0;
        set_req(0, 1'b1, 32'h5000, 10'd1);
        set_req(2, 1'b0, 32'h6000, 10'd2);
        I_Req = 4'b0101;
        repeat (2) tick();
        push(0, 1'b1, 32'h5000, 10'd1);
        push(2, 1'b0, 32'h6000, 10'd2);
        reset = 1'b1;
        serve(0, 1);
        I_Req = 4'b0100;
        tests_run++;
        if (O_Done !== 4'b0001) begin
            fails++;
            $display("FAIL mid_first done=%b want 0001", O_Done);
        end
        serve(0, 2);
        I_Req = 4'b0000;
        tests_run++;
        if (O_Done !== 4'b0100) begin
            fails++;
            $display("FAIL mid_second done=%b want 0100", O_Done);
        end
        tick();
    endtask

    task automatic test_req_drop();
        set_req(3, 1'b1, 32'h3000, 10'd2);
        push(3, 1'b1, 32'h3000, 10'd2);
        I_Req = 4'b1000;
        tick();
        I_Req = 4'b0000;
        set_req(3, 1'b0, 32'hDEAD, 10'd7);
        tick();
        tests_run++;
        if (O_Ext_Addr !== 32'h3000 || O_Ext_Len !== 10'd2 || O_Ext_St !== 1'b1 || O_Ext_Req !== 1'b1) begin
            fails++;
            $display("FAIL drop_latched addr=%h len=%0d st=%b req=%b want 3000 2 1 1",
                     O_Ext_Addr, O_Ext_Len, O_Ext_St, O_Ext_Req);
        end
        I_Ext_Ack = 1'b1; tick(); I_Ext_Ack = 1'b0;
        I_Ext_Beat = 1'b1; repeat (2) tick(); I_Ext_Beat = 1'b0;
        tests_run++;
        if (O_Done !== 4'b1000) begin
            fails++;
            $display("FAIL drop_done done=%b want 1000", O_Done);
        end
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_round_robin();
        test_ack_stall();
        test_zero_len();
        test_reset_mid();
        test_req_drop();
        tests_run++;
        if (cmd_q.size() != 0 || done_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_empty cmds_left=%0d dones_left=%0d want 0 0", cmd_q.size(), done_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
